// File: rtl/serial_pkg.sv
// serial_pkg
// Constants and the phase encoding shared by the transmit and receive sides
// of the 3-bit serial frame link.
package serial_pkg;

    localparam int         FRAME_W          = 3;
    localparam logic [2:0] ILLEGAL_SYM      = 3'b111;
    localparam logic [2:0] DEFAULT_IDLE_SYM = 3'b000;

    // Named by the frame bit on the line during that phase. The receiver
    // uses the same encoding.
    typedef enum logic [1:0] {
        PH2 = 2'd0,
        PH1 = 2'd1,
        PH0 = 2'd2
    } phase_e;

    function automatic logic is_illegal_sym(input logic [2:0] sym);
        return sym == ILLEGAL_SYM;
    endfunction

endpackage

// File: rtl/serial_frame_tx.sv
// serial_frame_tx
// Transmit side of the 3-bit serial frame link. Takes symbols over a
// valid/ready handshake, buffers at most one in a hold slot, and sends them
// MSB-first as back-to-back 3-bit frames. Idle frames fill the gaps.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   in_data      symbol to send (bit 2 first)
//   in_valid     in_data valid
//   in_ready     a symbol can be accepted this cycle
//   Dout         serial line (registered)
//   frame_start  high while Dout carries bit 2 of a frame
//   illegal      one-cycle pulse the cycle after a 3'b111 is accepted
//   frame_cnt    data frames loaded, wraps
//   illegal_cnt  3'b111 symbols accepted, saturates
module serial_frame_tx #(
    parameter int         FRAME_W       = serial_pkg::FRAME_W,
    parameter logic [2:0] IDLE_SYM      = serial_pkg::DEFAULT_IDLE_SYM,
    parameter bit         BLOCK_ILLEGAL = 1'b1,
    parameter int         CNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FRAME_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               Dout,
    output logic               frame_start,
    output logic               illegal,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic [CNT_W-1:0]   illegal_cnt
);
    import serial_pkg::*;

    // Idle must never look like the receiver's error pattern, and the
    // phase machine only knows three phases.
    if (IDLE_SYM == ILLEGAL_SYM) begin : g_idle_chk
        $error("serial_frame_tx: IDLE_SYM must not equal 3'b111");
    end
    if (FRAME_W != 3) begin : g_width_chk
        $error("serial_frame_tx: FRAME_W is fixed at 3");
    end

    phase_e             phase_q, phase_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic               hold_data_q, hold_data_d;   // slot word counts as data
    logic               frame_start_q, frame_start_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;

    logic               xfer;
    logic               in_is_illegal;
    logic               in_blocked;
    logic [FRAME_W-1:0] in_sym;
    logic               load_data;

    // A full slot is emptied by the PH0 load, so PH0 can always accept.
    assign in_ready      = !hold_full_q || (phase_q == PH0);
    assign xfer          = in_valid && in_ready;
    assign in_is_illegal = is_illegal_sym(in_data);
    assign in_blocked    = in_is_illegal && BLOCK_ILLEGAL;
    assign in_sym        = in_blocked ? IDLE_SYM : in_data;

    always_comb begin
        phase_d       = phase_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        hold_data_d   = hold_data_q;
        illegal_d     = xfer && in_is_illegal;
        illegal_cnt_d = illegal_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        load_data     = 1'b0;

        if (xfer && in_is_illegal && (illegal_cnt_q != '1)) begin
            illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
        end

        unique case (phase_q)
            PH2, PH1: begin
                phase_d = (phase_q == PH2) ? PH1 : PH0;
                shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                if (xfer) begin
                    hold_d      = in_sym;
                    hold_full_d = 1'b1;
                    hold_data_d = !in_blocked;
                end
            end
            PH0: begin
                phase_d = PH2;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    load_data   = hold_data_q;
                    // A word arriving now takes the slot just vacated.
                    hold_full_d = xfer;
                    if (xfer) begin
                        hold_d      = in_sym;
                        hold_data_d = !in_blocked;
                    end
                end else if (xfer) begin
                    shift_d   = in_sym;
                    load_data = !in_blocked;
                end else begin
                    shift_d = IDLE_SYM;
                end
            end
            default: begin
                phase_d     = PH2;
                shift_d     = IDLE_SYM;
                hold_full_d = 1'b0;
            end
        endcase

        if (load_data) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        frame_start_d = (phase_d == PH2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= PH2;
            shift_q       <= IDLE_SYM;
            hold_q        <= IDLE_SYM;
            hold_full_q   <= 1'b0;
            hold_data_q   <= 1'b0;
            frame_start_q <= 1'b1;
            illegal_q     <= 1'b0;
            frame_cnt_q   <= '0;
            illegal_cnt_q <= '0;
        end else begin
            phase_q       <= phase_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            hold_data_q   <= hold_data_d;
            frame_start_q <= frame_start_d;
            illegal_q     <= illegal_d;
            frame_cnt_q   <= frame_cnt_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign Dout        = shift_q[FRAME_W-1];
    assign frame_start = frame_start_q;
    assign illegal     = illegal_q;
    assign frame_cnt   = frame_cnt_q;
    assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two instances (illegal symbols blocked / passed)
// share one stimulus stream and are compared every cycle against a
// frame-level model (time slot mod 3, a FIFO of pending words).
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_data;
    logic       in_valid;

    logic       rdy0, dout0, fs0, ill0;
    logic       rdy1, dout1, fs1, ill1;
    logic [7:0] fcnt0, icnt0, fcnt1, icnt1;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    always #5 clk = ~clk;

    serial_frame_tx #(.BLOCK_ILLEGAL(1'b0)) u_pass (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy0), .Dout(dout0), .frame_start(fs0), .illegal(ill0),
        .frame_cnt(fcnt0), .illegal_cnt(icnt0)
    );

    serial_frame_tx #(.BLOCK_ILLEGAL(1'b1)) u_block (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy1), .Dout(dout1), .frame_start(fs1), .illegal(ill1),
        .frame_cnt(fcnt1), .illegal_cnt(icnt1)
    );

    // ---------------- reference model ----------------
    int         m_t;          // bit slot within the frame: 0 = first bit
    logic [2:0] m_pend[$];    // words accepted but not yet on the line
    logic [2:0] m_cur;
    logic       m_word;       // current frame carries a word (else idle)
    logic [7:0] m_fc0, m_fc1, m_ic;
    logic       m_ill;
    logic       m_acc;

    task automatic model_reset();
        m_t = 0;
        m_pend.delete();
        m_cur = 3'b000;
        m_word = 1'b0;
        m_fc0 = 0; m_fc1 = 0; m_ic = 0;
        m_ill = 1'b0;
        m_acc = 1'b0;
    endtask

    function automatic logic m_ready();
        return (m_pend.size() == 0) || (m_t == 2);
    endfunction

    function automatic logic [2:0] exp_frame(input int b);
        if (!m_word) return 3'b000;
        if (b == 1 && m_cur == 3'b111) return 3'b000;
        return m_cur;
    endfunction

    function automatic logic exp_dout(input int b);
        logic [2:0] f;
        f = exp_frame(b);
        return f[2 - m_t];
    endfunction

    task automatic model_step(input logic v, input logic [2:0] d);
        m_acc = v && m_ready();
        m_ill = m_acc && (d == 3'b111);
        if (m_acc) begin
            m_pend.push_back(d);
            if (d == 3'b111 && m_ic != 8'hff) m_ic = m_ic + 8'd1;
        end
        if (m_t == 2) begin
            if (m_pend.size() != 0) begin
                m_cur  = m_pend.pop_front();
                m_word = 1'b1;
                m_fc0  = m_fc0 + 8'd1;
                if (m_cur != 3'b111) m_fc1 = m_fc1 + 8'd1;
            end else begin
                m_word = 1'b0;
            end
            m_t = 0;
        end else begin
            m_t = m_t + 1;
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (!reset && cmp_en) begin
            chk("dout_pass",   {7'd0, dout0}, {7'd0, exp_dout(0)});
            chk("dout_block",  {7'd0, dout1}, {7'd0, exp_dout(1)});
            chk("fs_pass",     {7'd0, fs0},   {7'd0, m_t == 0});
            chk("fs_block",    {7'd0, fs1},   {7'd0, m_t == 0});
            chk("ready_pass",  {7'd0, rdy0},  {7'd0, m_ready()});
            chk("ready_block", {7'd0, rdy1},  {7'd0, m_ready()});
            chk("ill_pass",    {7'd0, ill0},  {7'd0, m_ill});
            chk("ill_block",   {7'd0, ill1},  {7'd0, m_ill});
            chk("fcnt_pass",   fcnt0, m_fc0);
            chk("fcnt_block",  fcnt1, m_fc1);
            chk("icnt_pass",   icnt0, m_ic);
            chk("icnt_block",  icnt1, m_ic);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic v, input logic [2:0] d);
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        if (!reset) model_step(v, d);
        @(negedge clk);
    endtask

    task automatic assert_reset();
        #2;
        reset    = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_reset();
        assert_reset();
        release_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] words [3];
        logic [8:0] stream;
        logic [11:0] rdy_exp;
        logic [5:0] bypass_bits;
        logic [2:0] rx0, rx1;
        int idx, n;

        reset = 1'b1; in_valid = 1'b0; in_data = 3'b000;
        model_reset();
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;

        // Idle after reset: line low, frame_start every third cycle.
        for (int i = 0; i < 9; i++) begin
            chk("idle_dout", {7'd0, dout0}, 8'd0);
            chk("idle_fs",   {7'd0, fs0},   {7'd0, (i % 3) == 0});
            chk("idle_fcnt", fcnt0, 8'd0);
            tick(1'b0, 3'b000);
        end

        // Bypass of 101 presented in PH0, then idle frame.
        do_reset();
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b000);
        tick(1'b1, 3'b101);
        bypass_bits = 6'b101000;
        for (int i = 0; i < 6; i++) begin
            chk("bypass_dout", {7'd0, dout0}, {7'd0, bypass_bits[5 - i]});
            chk("bypass_fs",   {7'd0, fs0},   {7'd0, (i % 3) == 0});
            tick(1'b0, 3'b000);
        end
        chk("bypass_fcnt", fcnt0, 8'd1);

        // Back-to-back words with valid held high.
        do_reset();
        words[0] = 3'b110; words[1] = 3'b011; words[2] = 3'b100;
        stream  = 9'b110011100;
        rdy_exp = 12'b1010_0100_1111;   // cycle 0 is the MSB
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 12) chk("b2b_ready", {7'd0, rdy0}, {7'd0, rdy_exp[11 - c]});
            if (c >= 3 && c <= 11)
                chk("b2b_dout", {7'd0, dout0}, {7'd0, stream[11 - c]});
            if (idx < 3) begin
                tick(1'b1, words[idx]);
                if (m_acc) idx++;
            end else begin
                tick(1'b0, 3'b000);
            end
        end
        chk("b2b_all_sent", idx[7:0], 8'd3);
        chk("b2b_fcnt", fcnt0, 8'd3);

        // Illegal symbol: blocked instance sends idle, pass instance sends 111.
        do_reset();
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b000);
        tick(1'b1, 3'b111);
        chk("ill_pulse_pass",  {7'd0, ill0}, 8'd1);
        chk("ill_pulse_block", {7'd0, ill1}, 8'd1);
        for (int i = 0; i < 3; i++) begin
            rx0[2 - i] = dout0;
            rx1[2 - i] = dout1;
            if (i == 1) chk("ill_pulse_once", {7'd0, ill0}, 8'd0);
            tick(1'b0, 3'b000);
        end
        chk("ill_rx_pass",    {5'd0, rx0}, 8'h07);
        chk("ill_rx_block",   {5'd0, rx1}, 8'h00);
        chk("ill_icnt",       icnt1, 8'd1);
        chk("ill_fcnt_block", fcnt1, 8'd0);
        chk("ill_fcnt_pass",  fcnt0, 8'd1);

        // Reset during bit 1 of 010 with 001 held in the slot.
        do_reset();
        tick(1'b0, 3'b000);
        tick(1'b0, 3'b000);
        tick(1'b1, 3'b010);
        tick(1'b1, 3'b001);
        chk("mid_pre_dout",  {7'd0, dout0}, 8'd1);
        chk("mid_pre_ready", {7'd0, rdy0},  8'd0);
        assert_reset();
        chk("mid_rst_dout",  {7'd0, dout0}, 8'd0);
        chk("mid_rst_fs",    {7'd0, fs0},   8'd1);
        chk("mid_rst_ready", {7'd0, rdy0},  8'd1);
        release_reset();
        for (int i = 0; i < 9; i++) begin
            chk("mid_after_dout", {7'd0, dout0}, 8'd0);
            tick(1'b0, 3'b000);
        end
        chk("mid_after_fcnt", fcnt0, 8'd0);

        // Randomised traffic with one reset in the middle.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            logic       v;
            logic [2:0] d;
            v = ($urandom_range(0, 3) != 0);
            d = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) d = 3'b111;
            if (c == 200) do_reset();
            tick(v, d);
        end

        // 300 illegal words: counter saturates, pass-side frame count wraps.
        do_reset();
        n = 0;
        for (int c = 0; c < 1200 && n < 300; c++) begin
            tick(1'b1, 3'b111);
            if (m_acc) n++;
        end
        repeat (6) tick(1'b0, 3'b000);
        chk("sat_accepted",   n[15:8] == 8'd1 ? n[7:0] : 8'hxx, 8'd44);
        chk("sat_icnt_pass",  icnt0, 8'd255);
        chk("sat_icnt_block", icnt1, 8'd255);
        chk("sat_fcnt_pass",  fcnt0, 8'd44);
        chk("sat_fcnt_block", fcnt1, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
